// File: rtl/spi_1.sv
// spi_1 : SPI mode-0 master for SD-card-style transactions.
//
// Each rising edge of spi_start (while idle) runs one complete transaction:
// command frame, wait for and receive the response, optionally wait for a
// start token and receive a data block, optionally send a data block.
// Payload bytes are fixed patterns produced here. Received bits are shifted
// into an internal register that is not exported.
//
// Ports:
//   clk                  system clock
//   rst                  synchronous reset, active low
//   clk_ss               SCK rate select (0 = DIV_SLOW, 1 = DIV_FAST)
//   spi_start            start request, rising-edge triggered
//   response_length      response bytes to receive
//   receive_data_length  data bytes to receive after the FE token
//   cmd_length           command bytes to send
//   send_data_length     data bytes to send after FF gap and FE token
//   CS, MOSI, SCK        SPI master outputs (CS active low)
//   MISO                 SPI master input
//   busy_spi             high while a transaction is active
//   valid_response       one-cycle pulse when the response is complete
//   valid_spi            one-cycle pulse at transaction end
`timescale 1ns/1ps
module spi_1 #(
  parameter int DIV_SLOW     = 250,
  parameter int DIV_FAST     = 5,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_ss,
  input  logic       spi_start,
  input  logic [5:0] response_length,
  input  logic [9:0] receive_data_length,
  input  logic [5:0] cmd_length,
  input  logic [9:0] send_data_length,
  output logic       CS,
  output logic       MOSI,
  output logic       SCK,
  input  logic       MISO,
  output logic       busy_spi,
  output logic       valid_response,
  output logic       valid_spi
);

  typedef enum logic [3:0] {
    IDLE, CMD, WAIT_RESP, RESP, WAIT_TOKEN, RX_DATA,
    TX_GAP, TX_TOKEN, TX_DATA, DONE
  } state_t;

  localparam int CW = $clog2(DIV_SLOW + 1);
  // SCK is low while div_cnt < ceil(DIV/2), high for the rest of the period.
  localparam logic [CW-1:0] SLOW_RISE = CW'((DIV_SLOW + 1) / 2 - 1);
  localparam logic [CW-1:0] SLOW_LAST = CW'(DIV_SLOW - 1);
  localparam logic [CW-1:0] FAST_RISE = CW'((DIV_FAST + 1) / 2 - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(DIV_FAST - 1);
  localparam logic [9:0]    TO_LAST   = 10'(RESP_TIMEOUT - 1);

  state_t          state, nxt, start_state, after_cmd, after_resp, after_rx;
  logic            start_d, fast, adv, byte_end;
  logic [5:0]      cmd_len, resp_len;
  logic [9:0]      rx_len, tx_len, byte_cnt, byte_nx;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   div_cnt, rise_at, last_at;
  logic [7:0]      tx_sr, rx_sr, nxt_byte, start_byte, cont_byte;

  function automatic logic [7:0] cmd_byte(input logic [9:0] idx);
    case (idx)
      10'd0:                      cmd_byte = 8'h40;
      10'd1, 10'd2, 10'd3, 10'd4: cmd_byte = 8'h00;
      10'd5:                      cmd_byte = 8'h95;
      default:                    cmd_byte = 8'hFF;
    endcase
  endfunction

  // First byte shifted out when a phase is entered; receive phases send FF.
  function automatic logic [7:0] entry_byte(input state_t s);
    case (s)
      CMD:      entry_byte = 8'h40;
      TX_TOKEN: entry_byte = 8'hFE;
      TX_DATA:  entry_byte = 8'h00;
      default:  entry_byte = 8'hFF;
    endcase
  endfunction

  assign rise_at  = fast ? FAST_RISE : SLOW_RISE;
  assign last_at  = fast ? FAST_LAST : SLOW_LAST;
  assign byte_end = (bit_cnt == 3'd7);
  assign byte_nx  = byte_cnt + 10'd1;

  // Phase skipping: zero-length phases fall through to the next one.
  assign after_rx    = (tx_len != 10'd0) ? TX_GAP : DONE;
  assign after_resp  = (rx_len != 10'd0) ? WAIT_TOKEN : after_rx;
  assign after_cmd   = (resp_len != 6'd0) ? WAIT_RESP : after_rx;
  assign start_state = (cmd_length != 6'd0)       ? CMD :
                       (response_length != 6'd0)  ? WAIT_RESP :
                       (send_data_length != 10'd0) ? TX_GAP : DONE;

  assign start_byte = entry_byte(start_state);
  assign nxt_byte   = entry_byte(nxt);
  assign cont_byte  = (state == CMD)     ? cmd_byte(byte_nx) :
                      (state == TX_DATA) ? byte_nx[7:0] : 8'hFF;

  // Phase exit decision, evaluated on each SCK rising (sampling) edge.
  always_comb begin
    adv = 1'b0;
    nxt = state;
    case (state)
      CMD:
        if (byte_end && byte_cnt == {4'd0, cmd_len} - 10'd1) begin
          adv = 1'b1;
          nxt = after_cmd;
        end
      WAIT_RESP:
        if (!MISO) begin
          adv = 1'b1;
          nxt = RESP;
        end else if (byte_end && byte_cnt == TO_LAST) begin
          adv = 1'b1;
          nxt = DONE;
        end
      RESP:
        if (byte_end && byte_cnt == {4'd0, resp_len} - 10'd1) begin
          adv = 1'b1;
          nxt = after_resp;
        end
      WAIT_TOKEN:
        if (!MISO) begin
          adv = 1'b1;
          nxt = RX_DATA;
        end
      RX_DATA:
        if (byte_end && byte_cnt == rx_len - 10'd1) begin
          adv = 1'b1;
          nxt = after_rx;
        end
      TX_GAP:
        if (byte_end) begin
          adv = 1'b1;
          nxt = TX_TOKEN;
        end
      TX_TOKEN:
        if (byte_end) begin
          adv = 1'b1;
          nxt = TX_DATA;
        end
      TX_DATA:
        if (byte_end && byte_cnt == tx_len - 10'd1) begin
          adv = 1'b1;
          nxt = DONE;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      start_d        <= 1'b1;
      CS             <= 1'b1;
      SCK            <= 1'b0;
      MOSI           <= 1'b1;
      busy_spi       <= 1'b0;
      valid_response <= 1'b0;
      valid_spi      <= 1'b0;
    end else begin
      start_d        <= spi_start;
      valid_response <= 1'b0;
      valid_spi      <= 1'b0;
      case (state)
        IDLE:
          if (spi_start && !start_d) begin
            fast     <= clk_ss;
            cmd_len  <= cmd_length;
            resp_len <= response_length;
            rx_len   <= receive_data_length;
            tx_len   <= send_data_length;
            CS       <= 1'b0;
            busy_spi <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 10'd0;
            tx_sr    <= start_byte;
            MOSI     <= start_byte[7];
            state    <= start_state;
          end
        DONE:
          // Finish the pending falling edge, then hold SCK low for one
          // low half-period before releasing CS.
          if (SCK) begin
            if (div_cnt == last_at) begin
              SCK     <= 1'b0;
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + CW'(1);
            end
          end else if (div_cnt == rise_at) begin
            CS        <= 1'b1;
            MOSI      <= 1'b1;
            busy_spi  <= 1'b0;
            valid_spi <= 1'b1;
            state     <= IDLE;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        default:
          if (div_cnt == last_at) begin
            SCK     <= 1'b0;
            div_cnt <= '0;
            MOSI    <= tx_sr[7];
          end else begin
            div_cnt <= div_cnt + CW'(1);
            if (div_cnt == rise_at) begin
              SCK   <= 1'b1;
              rx_sr <= {rx_sr[6:0], MISO};
              if (adv) begin
                state          <= nxt;
                // The start bit that ends WAIT_RESP is bit 7 of response byte 0.
                bit_cnt        <= (state == WAIT_RESP) ? 3'd1 : 3'd0;
                byte_cnt       <= 10'd0;
                tx_sr          <= nxt_byte;
                valid_response <= (state == RESP);
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_end) begin
                  byte_cnt <= byte_nx;
                  tx_sr    <= cont_byte;
                end else begin
                  tx_sr <= {tx_sr[6:0], 1'b1};
                end
              end
            end
          end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_1.sv
// tb_spi_1 : directed bench for spi_1 (SD-style SPI master).
// A MISO slave model plays back a per-transaction bit table (bit i is presented
// before SCK rise i); monitors log MOSI at each SCK rise, edge times and the
// status pulses, and the main sequence compares them with hand-derived values.
`timescale 1ns/1ps
module tb_spi_1;

  logic       clk = 1'b0;
  logic       rst, clk_ss, spi_start;
  logic [5:0] response_length, cmd_length;
  logic [9:0] receive_data_length, send_data_length;
  logic       CS, MOSI, SCK, busy_spi, valid_response, valid_spi;
  logic       MISO;

  int vectors = 0;
  int miscompares = 0;

  logic miso_bits [0:1023];
  int   fall_cnt = 0;
  logic mosi_log [0:4095];
  int   rise_n = 0;
  time  t_last = 0, t_prev = 0, t_fall = 0, t_first = 0;
  time  t_cs_fall = 0, t_cs_rise = 0;
  logic first_pend = 1'b0;
  int   vr_cnt = 0, vr_at = 0, vs_cnt = 0, vs_at = 0;
  logic vs_cs, vs_busy;

  always #5 clk = ~clk;

  spi_1 dut (
    .clk(clk), .rst(rst), .clk_ss(clk_ss), .spi_start(spi_start),
    .response_length(response_length), .receive_data_length(receive_data_length),
    .cmd_length(cmd_length), .send_data_length(send_data_length),
    .CS(CS), .MOSI(MOSI), .SCK(SCK), .MISO(MISO),
    .busy_spi(busy_spi), .valid_response(valid_response), .valid_spi(valid_spi)
  );

  assign MISO = miso_bits[fall_cnt[9:0]];

  // Slave side: advance to the next bit on each SCK fall, rewind on CS release.
  always @(negedge SCK or posedge CS) begin
    if (CS === 1'b1) begin
      fall_cnt  = 0;
      t_cs_rise = $time;
    end else begin
      fall_cnt = fall_cnt + 1;
      t_fall   = $time;
    end
  end

  always @(posedge SCK or negedge CS) begin
    if (SCK !== 1'b1) begin
      t_cs_fall  = $time;
      first_pend = 1'b1;
    end else begin
      mosi_log[rise_n] = MOSI;
      rise_n = rise_n + 1;
      if (first_pend) begin
        t_first    = $time;
        first_pend = 1'b0;
      end
      t_prev = t_last;
      t_last = $time;
    end
  end

  always @(posedge clk) begin
    if (valid_response === 1'b1) begin
      vr_cnt = vr_cnt + 1;
      vr_at  = rise_n;
    end
    if (valid_spi === 1'b1) begin
      vs_cnt  = vs_cnt + 1;
      vs_at   = rise_n;
      vs_cs   = CS;
      vs_busy = busy_spi;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] log_byte(input int start);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], mosi_log[start + i]};
    return b;
  endfunction

  function automatic int ones(input int start, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (mosi_log[start + i] === 1'b1) c++;
    return c;
  endfunction

  task automatic set_miso_all(input logic v);
    for (int i = 0; i < 1024; i++) miso_bits[i] = v;
  endtask

  task automatic start_txn(input logic ss, input int c, input int r, input int rx, input int tx);
    @(negedge clk);
    clk_ss              = ss;
    cmd_length          = 6'(c);
    response_length     = 6'(r);
    receive_data_length = 10'(rx);
    send_data_length    = 10'(tx);
    spi_start           = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input int prev);
    int n = 0;
    while (vs_cnt == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int base, vr0, vs0;
    logic [7:0] cmd_exp [0:5];
    cmd_exp[0] = 8'h40; cmd_exp[1] = 8'h00; cmd_exp[2] = 8'h00;
    cmd_exp[3] = 8'h00; cmd_exp[4] = 8'h00; cmd_exp[5] = 8'h95;

    rst = 1'b0; spi_start = 1'b0; clk_ss = 1'b0;
    cmd_length = '0; response_length = '0;
    receive_data_length = '0; send_data_length = '0;
    set_miso_all(1'b1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset CS", CS, 1);
    chk("reset SCK", SCK, 0);
    chk("reset MOSI", MOSI, 1);
    chk("reset busy", busy_spi, 0);
    chk("reset valid_response pulses", vr_cnt, 0);
    chk("reset valid_spi pulses", vs_cnt, 0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);

    // Slow read: cmd 6, resp 1 (0x08), token, 5 data bytes
    set_miso_all(1'b1);
    for (int i = 48; i <= 51; i++) miso_bits[i] = 1'b0;
    for (int i = 53; i <= 56; i++) miso_bits[i] = 1'b0;
    for (int i = 57; i < 97; i++) miso_bits[i] = i[0];
    base = rise_n; vr0 = vr_cnt; vs0 = vs_cnt;
    start_txn(1'b0, 6, 1, 5, 0);
    chk("slow start CS", CS, 0);
    chk("slow start busy", busy_spi, 1);
    // Inputs changed mid-transaction must be ignored
    spi_start = 1'b0; clk_ss = 1'b1; cmd_length = 6'd1;
    response_length = 6'd0; receive_data_length = 10'd0; send_data_length = 10'd7;
    wait_done(30000, vs0);
    chk("slow valid_spi count", vs_cnt - vs0, 1);
    for (int k = 0; k < 6; k++) chk($sformatf("slow cmd byte %0d", k), log_byte(base + 8 * k), cmd_exp[k]);
    chk("slow MOSI idle during rx", ones(base + 48, 49), 49);
    chk("slow SCK period ns", t_last - t_prev, 2500);
    chk("slow SCK high ns", t_fall - t_last, 1250);
    chk("slow first rise delay ns", t_first - t_cs_fall, 1250);
    chk("slow CS release delay ns", t_cs_rise - t_fall, 1250);
    chk("slow valid_response count", vr_cnt - vr0, 1);
    chk("slow valid_response at rise", vr_at - base, 56);
    chk("slow total SCK rises", rise_n - base, 97);
    chk("slow valid_spi at rise", vs_at - base, 97);
    chk("slow CS with valid_spi", vs_cs, 1);
    chk("slow busy with valid_spi", vs_busy, 0);
    chk("slow CS after", CS, 1);

    // Fast write: two fill bits, 5 response bytes, then FF FE 00 01 02
    set_miso_all(1'b1);
    for (int i = 50; i < 130; i++) miso_bits[i] = 1'b0;
    base = rise_n; vr0 = vr_cnt; vs0 = vs_cnt;
    start_txn(1'b1, 6, 5, 0, 3);
    spi_start = 1'b0;
    wait_done(2000, vs0);
    chk("fast valid_spi count", vs_cnt - vs0, 1);
    chk("fast cmd byte 5", log_byte(base + 40), 8'h95);
    chk("fast valid_response at rise", vr_at - base, 90);
    chk("fast valid_response count", vr_cnt - vr0, 1);
    chk("fast gap byte", log_byte(base + 90), 8'hFF);
    chk("fast token byte", log_byte(base + 98), 8'hFE);
    chk("fast data byte 0", log_byte(base + 106), 8'h00);
    chk("fast data byte 1", log_byte(base + 114), 8'h01);
    chk("fast data byte 2", log_byte(base + 122), 8'h02);
    chk("fast total SCK rises", rise_n - base, 130);
    chk("fast SCK period ns", t_last - t_prev, 50);
    chk("fast SCK high ns", t_fall - t_last, 20);
    chk("fast first rise delay ns", t_first - t_cs_fall, 30);
    chk("fast CS release delay ns", t_cs_rise - t_fall, 30);

    // Response timeout: MISO stuck high, later phases must be skipped
    set_miso_all(1'b1);
    base = rise_n; vr0 = vr_cnt; vs0 = vs_cnt;
    start_txn(1'b1, 6, 1, 2, 2);
    spi_start = 1'b0;
    wait_done(3000, vs0);
    chk("timeout valid_spi count", vs_cnt - vs0, 1);
    chk("timeout total SCK rises", rise_n - base, 176);
    chk("timeout no valid_response", vr_cnt - vr0, 0);

    // Level-held start with all lengths zero
    base = rise_n; vs0 = vs_cnt;
    start_txn(1'b1, 0, 0, 0, 0);
    wait_done(100, vs0);
    chk("zero-length valid_spi count", vs_cnt - vs0, 1);
    chk("zero-length SCK rises", rise_n - base, 0);
    chk("zero-length CS low ns", t_cs_rise - t_cs_fall, 30);
    repeat (20) @(negedge clk);
    chk("held start busy", busy_spi, 0);
    chk("held start CS", CS, 1);
    chk("held start no new valid_spi", vs_cnt - vs0, 1);
    spi_start = 1'b0;
    @(negedge clk);
    spi_start = 1'b1;
    @(negedge clk);
    chk("restart busy", busy_spi, 1);
    chk("restart CS", CS, 0);
    wait_done(100, vs0 + 1);
    chk("restart valid_spi count", vs_cnt - vs0, 2);

    // Reset during the command phase
    spi_start = 1'b0;
    base = rise_n; vs0 = vs_cnt;
    start_txn(1'b1, 6, 0, 0, 0);
    spi_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre-abort busy", busy_spi, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort CS", CS, 1);
    chk("abort SCK", SCK, 0);
    chk("abort busy", busy_spi, 0);
    chk("abort MOSI", MOSI, 1);
    @(negedge clk) rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort no valid_spi", vs_cnt - vs0, 0);

    // Recovery: command-only transaction after the abort
    base = rise_n; vs0 = vs_cnt;
    start_txn(1'b1, 6, 0, 0, 0);
    spi_start = 1'b0;
    wait_done(1000, vs0);
    chk("recovery valid_spi count", vs_cnt - vs0, 1);
    chk("recovery SCK rises", rise_n - base, 48);
    chk("recovery cmd byte 0", log_byte(base), 8'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
